// File: rtl/blink_sequencer.sv
// blink_sequencer: commandable LED blink pattern generator with valid/ready command intake
module blink_sequencer #(
    parameter int CountWidth  = 32,
    parameter int RepeatWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [CountWidth-1:0]  cmd_on_i,
    input  logic [CountWidth-1:0]  cmd_off_i,
    input  logic [RepeatWidth-1:0] cmd_repeat_i,
    input  logic                   abort_i,
    output logic                   led_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [RepeatWidth-1:0] blink_count_o
);
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
    state_t                 state;
    logic [CountWidth-1:0]  timer;
    logic [CountWidth-1:0]  on_q;
    logic [CountWidth-1:0]  off_q;
    logic [RepeatWidth-1:0] rep_q;
    logic [RepeatWidth-1:0] count_nxt;
    assign count_nxt   = blink_count_o + 1'b1;
    assign busy_o      = state != IDLE;
    assign cmd_ready_o = state == IDLE;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            timer         <= '0;
            on_q          <= '0;
            off_q         <= '0;
            rep_q         <= '0;
            led_o         <= 1'b0;
            done_o        <= 1'b0;
            blink_count_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (cmd_valid_i) begin
                    on_q          <= cmd_on_i;
                    off_q         <= cmd_off_i;
                    rep_q         <= cmd_repeat_i;
                    blink_count_o <= '0;
                    if (cmd_repeat_i == '0 || cmd_on_i == '0) begin
                        done_o <= 1'b1;
                    end else begin
                        state <= ON;
                        led_o <= 1'b1;
                        timer <= cmd_on_i - 1'b1;
                    end
                end
                ON: if (abort_i) begin
                    state <= IDLE;
                    led_o <= 1'b0;
                end else if (timer != '0) begin
                    timer <= timer - 1'b1;
                end else begin
                    blink_count_o <= count_nxt;
                    if (off_q != '0) begin
                        state <= OFF;
                        led_o <= 1'b0;
                        timer <= off_q - 1'b1;
                    end else if (count_nxt == rep_q) begin
                        state  <= IDLE;
                        led_o  <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        timer <= on_q - 1'b1;
                    end
                end
                OFF: if (abort_i) begin
                    state <= IDLE;
                end else if (timer != '0) begin
                    timer <= timer - 1'b1;
                end else if (blink_count_o == rep_q) begin
                    state  <= IDLE;
                    done_o <= 1'b1;
                end else begin
                    state <= ON;
                    led_o <= 1'b1;
                    timer <= on_q - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
